// File: rtl/modo_pratica_unidade_controle.sv
// Moore control FSM for the practice-mode memory game: sequences the show/play phases and tracks errors and score.
// Outputs decode the registered state (no input-to-output path); tentativas/pontos update on entry into their states.
module modo_pratica_unidade_controle #(
  parameter int MAX_TENTATIVAS = 3,
  parameter int W_TENT         = 2,
  parameter int W_PONTOS       = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic [1:0]          modo,
  input  logic                fimTF,
  input  logic                fimCR,
  input  logic                enderecoIgualRodada,
  input  logic                nota_feita,
  input  logic                nota_correta,
  input  logic                tempo_correto,
  input  logic                tempo_correto_baixo,
  input  logic                fimTempo,
  input  logic                tentar_dnv_rep,
  input  logic                tentar_dnv,
  input  logic                apresenta_ultima,
  output logic                zeraC,
  output logic                contaC,
  output logic                zeraTF,
  output logic                contaTF,
  output logic                zeraCR,
  output logic                contaCR,
  output logic                zeraTempo,
  output logic                contaTempo,
  output logic                zeraR,
  output logic                registraR,
  output logic                toca,
  output logic                leds_mem,
  output logic                vez_jogador,
  output logic                ganhou,
  output logic                perdeu,
  output logic                fim_jogo,
  output logic [W_TENT-1:0]   tentativas,
  output logic [W_PONTOS-1:0] pontos,
  output logic [4:0]          db_estado
);

  typedef enum logic [4:0] {
    INICIAL        = 5'h00,
    INICIALIZA     = 5'h01,
    INICIO_RODADA  = 5'h02,
    MOSTRA         = 5'h03,
    ESPERA_MOSTRA  = 5'h04,
    MOSTRA_PROXIMO = 5'h05,
    INICIO_NOTA    = 5'h06,
    ESPERA_NOTA    = 5'h07,
    COMPARA        = 5'h09,
    ACERTOU        = 5'h0A,
    PROXIMA_NOTA   = 5'h0B,
    APAGA_MOSTRA   = 5'h0D,
    PROXIMA_RODADA = 5'h13,
    ERROU          = 5'h14,
    TOCA_NOTA      = 5'h17,
    ESPERA_MOSTRA2 = 5'h18,
    FIM_JOGO       = 5'h1A
  } estado_t;

  localparam logic [W_TENT-1:0] MAX_T = W_TENT'(MAX_TENTATIVAS);

  estado_t    estado, proximo;
  logic [1:0] modo_reg;
  logic       esgotou;
  logic       entra;

  // Mode 3 behaves like strict mode, so bit 1 alone flags "strict".
  assign esgotou = modo_reg[1] | ((modo_reg == 2'd1) && (tentativas >= MAX_T));
  assign entra   = (proximo != estado);

  always_comb begin
    proximo = estado;
    case (estado)
      INICIAL:        if (iniciar) proximo = INICIALIZA;
      INICIALIZA:     proximo = INICIO_RODADA;
      INICIO_RODADA:  if (fimTF) proximo = MOSTRA;
      MOSTRA:         proximo = ESPERA_MOSTRA;
      ESPERA_MOSTRA:  if (tempo_correto_baixo)
                        proximo = enderecoIgualRodada ? INICIO_NOTA : APAGA_MOSTRA;
      APAGA_MOSTRA:   if (fimTF) proximo = MOSTRA_PROXIMO;
      MOSTRA_PROXIMO: proximo = MOSTRA;
      INICIO_NOTA:    proximo = ESPERA_NOTA;
      ESPERA_NOTA:    if (fimTempo) proximo = ERROU;
                      else if (nota_feita) proximo = TOCA_NOTA;
      TOCA_NOTA:      if (!nota_feita) proximo = COMPARA;
      COMPARA:        if (!nota_correta || !tempo_correto) proximo = ERROU;
                      else if (enderecoIgualRodada) proximo = fimCR ? ACERTOU : PROXIMA_RODADA;
                      else proximo = PROXIMA_NOTA;
      PROXIMA_NOTA:   proximo = ESPERA_NOTA;
      PROXIMA_RODADA: proximo = INICIO_RODADA;
      ERROU:          if (esgotou) proximo = FIM_JOGO;
                      else if (tentar_dnv_rep) proximo = INICIO_RODADA;
                      else if (tentar_dnv) proximo = INICIO_NOTA;
                      else if (apresenta_ultima) proximo = ESPERA_MOSTRA2;
      ESPERA_MOSTRA2: if (tempo_correto_baixo) proximo = ESPERA_NOTA;
      ACERTOU,
      FIM_JOGO:       if (iniciar) proximo = INICIALIZA;
      default:        proximo = INICIAL;
    endcase
  end

  // Counters act on the transition so ERROU already sees the updated error count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado     <= INICIAL;
      modo_reg   <= 2'd0;
      tentativas <= '0;
      pontos     <= '0;
    end else begin
      estado <= proximo;
      if (estado == INICIALIZA) modo_reg <= modo;

      if (entra && (proximo == INICIALIZA || proximo == PROXIMA_RODADA))
        tentativas <= '0;
      else if (entra && proximo == ERROU && tentativas != '1)
        tentativas <= tentativas + 1'b1;

      if (entra && proximo == INICIALIZA)
        pontos <= '0;
      else if (entra && (proximo == PROXIMA_RODADA || proximo == ACERTOU) && pontos != '1)
        pontos <= pontos + 1'b1;
    end
  end

  assign zeraR       = (estado == INICIAL);
  assign zeraCR      = (estado == INICIALIZA);
  assign zeraC       = (estado == INICIO_NOTA) || (estado == INICIO_RODADA);
  assign zeraTempo   = (estado == PROXIMA_NOTA) || (estado == INICIO_NOTA) ||
                       (estado == INICIALIZA) || (estado == ERROU);
  assign zeraTF      = (estado == MOSTRA) || (estado == INICIALIZA) || (estado == INICIO_NOTA);
  assign contaTF     = (estado == APAGA_MOSTRA) || (estado == INICIO_RODADA);
  assign contaC      = (estado == MOSTRA_PROXIMO) || (estado == PROXIMA_NOTA);
  assign vez_jogador = (estado == ESPERA_NOTA);
  assign contaTempo  = vez_jogador;
  assign registraR   = (estado == TOCA_NOTA);
  assign contaCR     = (estado == PROXIMA_RODADA);
  assign ganhou      = (estado == ACERTOU);
  assign fim_jogo    = (estado == FIM_JOGO);
  assign perdeu      = (estado == ERROU) || fim_jogo;
  assign leds_mem    = (estado == ESPERA_MOSTRA) || (estado == ESPERA_MOSTRA2);
  assign toca        = leds_mem || registraR;
  assign db_estado   = estado;

endmodule

// File: tb/tb_modo_pratica_unidade_controle.sv
// Randomized game-play bench: a player/datapath agent drives the FSM, a game-level model queues expected events.
module tb_modo_pratica_unidade_controle;

  localparam int MAXT = 3;
  localparam int K_ERR = 0, K_ROUND = 1, K_WIN = 2, K_LOSE = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic iniciar = 0, fimTF = 0, fimCR = 0, enderecoIgualRodada = 0;
  logic nota_feita = 0, nota_correta = 0, tempo_correto = 0, tempo_correto_baixo = 0, fimTempo = 0;
  logic tentar_dnv_rep = 0, tentar_dnv = 0, apresenta_ultima = 0;
  logic [1:0] modo = 2'd0;
  logic zeraC, contaC, zeraTF, contaTF, zeraCR, contaCR, zeraTempo, contaTempo, zeraR, registraR;
  logic toca, leds_mem, vez_jogador, ganhou, perdeu, fim_jogo;
  logic [1:0] tentativas;
  logic [7:0] pontos;
  logic [4:0] db_estado;

  always #5 clock = ~clock;

  modo_pratica_unidade_controle #(.MAX_TENTATIVAS(MAXT), .W_TENT(2), .W_PONTOS(8)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .modo(modo),
    .fimTF(fimTF), .fimCR(fimCR), .enderecoIgualRodada(enderecoIgualRodada),
    .nota_feita(nota_feita), .nota_correta(nota_correta), .tempo_correto(tempo_correto),
    .tempo_correto_baixo(tempo_correto_baixo), .fimTempo(fimTempo),
    .tentar_dnv_rep(tentar_dnv_rep), .tentar_dnv(tentar_dnv), .apresenta_ultima(apresenta_ultima),
    .zeraC(zeraC), .contaC(contaC), .zeraTF(zeraTF), .contaTF(contaTF), .zeraCR(zeraCR),
    .contaCR(contaCR), .zeraTempo(zeraTempo), .contaTempo(contaTempo), .zeraR(zeraR),
    .registraR(registraR), .toca(toca), .leds_mem(leds_mem), .vez_jogador(vez_jogador),
    .ganhou(ganhou), .perdeu(perdeu), .fim_jogo(fim_jogo), .tentativas(tentativas),
    .pontos(pontos), .db_estado(db_estado)
  );

  typedef struct {
    int kind;
    int pontos;
    int tent;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 0;

  // Datapath stand-in: note address, round counter and show timer.
  int dp_c = 0, dp_cr = 0, dp_tf = 0;

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  function automatic int code_of(input int k);
    case (k)
      K_ERR:   return 32'h14;
      K_ROUND: return 32'h13;
      K_WIN:   return 32'h0A;
      default: return 32'h1A;
    endcase
  endfunction

  task automatic check_event(input int k);
    exp_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event kind=%0d db_estado=%0h pontos=%0d tentativas=%0d (none expected)",
               k, db_estado, pontos, tentativas);
    end else begin
      e = exp_q.pop_front();
      if (k != e.kind || int'(db_estado) != code_of(e.kind) || int'(pontos) != e.pontos ||
          int'(tentativas) != e.tent || (e.kind == K_LOSE && !perdeu)) begin
        n_fail++;
        $display("FAIL event got kind=%0d db=%0h pontos=%0d tent=%0d perdeu=%0b, expected kind=%0d db=%0h pontos=%0d tent=%0d",
                 k, db_estado, pontos, tentativas, perdeu, e.kind, code_of(e.kind), e.pontos, e.tent);
      end
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents a game event.
  initial begin
    bit p_err, p_win, p_lose, in_err;
    int k;
    p_err = 0; p_win = 0; p_lose = 0;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        in_err = perdeu && !fim_jogo;
        k = -1;
        if (in_err && !p_err)          k = K_ERR;
        else if (contaCR)              k = K_ROUND;
        else if (ganhou && !p_win)     k = K_WIN;
        else if (fim_jogo && !p_lose)  k = K_LOSE;
        if (k >= 0) check_event(k);
        p_err = in_err; p_win = ganhou; p_lose = fim_jogo;
      end else begin
        p_err = 0; p_win = 0; p_lose = 0;
      end
    end
  end

  task automatic check_idle(input string name);
    logic [15:0] ctl;
    ctl = {zeraC, contaC, zeraTF, contaTF, zeraCR, contaCR, zeraTempo, contaTempo,
           zeraR, registraR, toca, leds_mem, vez_jogador, ganhou, perdeu, fim_jogo};
    n_tests++;
    if (ctl != 16'h0080 || db_estado != 5'h00 || pontos != 8'd0 || tentativas != 2'd0) begin
      n_fail++;
      $display("FAIL %s ctl=%h db=%0h pontos=%0d tent=%0d, expected ctl=0080 db=0 pontos=0 tent=0",
               name, ctl, db_estado, pontos, tentativas);
    end
  endtask

  // Plays one game; the player's decisions also push the expected events.
  task automatic play_game(input int m, input int n, input int err_pct, input int abort_at);
    int  latched, rounds_done, err_round, total_err, cyc, t, hold;
    bit  fin, act_pending;
    logic s_zc, s_cc, s_zcr, s_ccr, s_ztf, s_ctf;
    latched = (m >= 2) ? 2 : m;
    rounds_done = 0; err_round = 0; total_err = 0; cyc = 0; hold = 0;
    fin = 0; act_pending = 0;
    modo = 2'(m);
    while (!fin && cyc < 4000) begin
      @(negedge clock);
      iniciar = (cyc == 0);
      cyc++;
      if (cyc > 1 && (ganhou || fim_jogo)) begin
        fin = 1;
        break;
      end
      if (abort_at > 0 && rounds_done == abort_at && vez_jogador) begin
        fin = 1;
        break;
      end
      fimTF = (dp_tf >= 2);
      enderecoIgualRodada = (dp_c == dp_cr);
      fimCR = (dp_cr == n - 1);
      tempo_correto_baixo = 1'($urandom_range(0, 1));
      if (vez_jogador) begin
        if (!act_pending) begin
          act_pending = 1;
          hold = $urandom_range(0, 2);
          if ($urandom_range(0, 3) == 0) modo = 2'($urandom_range(0, 3));
          if (total_err < 6 && $urandom_range(1, 100) <= err_pct) begin
            err_round++; total_err++;
            t = sat3(err_round);
            exp_q.push_back('{K_ERR, rounds_done, t});
            if (latched == 2 || (latched == 1 && t >= MAXT))
              exp_q.push_back('{K_LOSE, rounds_done, t});
            case ($urandom_range(0, 2))
              0: begin nota_feita = 1; nota_correta = 0; tempo_correto = 1'($urandom_range(0, 1)); end
              1: begin nota_feita = 1; nota_correta = 1; tempo_correto = 0; end
              default: begin
                fimTempo = 1; nota_feita = 1'($urandom_range(0, 1));
                nota_correta = 1; tempo_correto = 1;
              end
            endcase
          end else begin
            nota_feita = 1; nota_correta = 1; tempo_correto = 1;
            if (dp_c == dp_cr) begin
              rounds_done++;
              if (rounds_done == n) exp_q.push_back('{K_WIN, rounds_done, sat3(err_round)});
              else exp_q.push_back('{K_ROUND, rounds_done, 0});
              err_round = 0;
            end
          end
        end
      end else if (registraR) begin
        nota_feita = (hold > 0);
        if (hold > 0) hold--;
        fimTempo = 0;
      end else begin
        nota_feita = 0; fimTempo = 0; act_pending = 0;
      end
      if (perdeu && !fim_jogo)
        {tentar_dnv_rep, tentar_dnv, apresenta_ultima} = 3'($urandom_range(0, 7));
      else
        {tentar_dnv_rep, tentar_dnv, apresenta_ultima} = 3'b000;
      s_zc = zeraC; s_cc = contaC; s_zcr = zeraCR; s_ccr = contaCR; s_ztf = zeraTF; s_ctf = contaTF;
      @(posedge clock);
      if (s_zcr) dp_cr = 0; else if (s_ccr) dp_cr++;
      if (s_zc) dp_c = 0; else if (s_cc) dp_c++;
      if (s_ztf) dp_tf = 0; else if (s_ctf) dp_tf++;
    end
    iniciar = 0;
    if (!fin) begin
      n_tests++; n_fail++;
      $display("FAIL game_timeout modo=%0d rounds=%0d db_estado=%0h, expected game end within 4000 cycles",
               m, n, db_estado);
    end
  endtask

  initial begin
    #2;
    check_idle("reset_state");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    mon_en = 1;

    play_game(0, 2, 0, 0);     // clean win
    play_game(1, 3, 100, 0);   // limited mode runs out of attempts
    play_game(2, 2, 100, 0);   // strict mode ends on first error
    play_game(3, 2, 100, 0);   // mode 3 behaves as strict
    play_game(1, 2, 40, 0);
    play_game(0, 3, 60, 0);    // many errors: attempt counter saturates
    for (int g = 0; g < 12; g++)
      play_game($urandom_range(0, 3), $urandom_range(1, 4), $urandom_range(0, 50), 0);

    // Mid-game asynchronous reset with three rounds already scored.
    play_game(0, 5, 0, 3);
    repeat (3) @(negedge clock);
    n_tests++;
    if (exp_q.size() != 0 || pontos != 8'd3 || db_estado != 5'h07) begin
      n_fail++;
      $display("FAIL pre_reset pending=%0d pontos=%0d db=%0h, expected pending=0 pontos=3 db=7",
               exp_q.size(), pontos, db_estado);
    end
    mon_en = 0;
    #3 reset = 1'b0;
    #1 check_idle("async_reset");
    #1 reset = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
